dma_controller: RTL and testbench
=================================

Name: dma_controller

Overview:
- Bus-master DMA engine: the reading end of the external device's offset/data interface.
- On a CPU command it requests the bus (br/bg handshake) and walks device offsets 0..N-1.
- Each 4-word (64-bit) block read from the device is written into memory as one line write.
- Completion is signalled to the CPU with a one-cycle interrupt pulse.
- Sits between CPU, memory port and external_device in the DMA top level.

Parameters:
- WORD_SIZE, 16, memory word / address width.
- DATA_SIZE, 3, number of 64-bit blocks held by the device.
- DEVICE_BIT_LEN, 2, width of the device offset bus.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  CPU issues a transfer command.
- cmd_addr  in  WORD_SIZE  destination base word address.
- cmd_blocks  in  DEVICE_BIT_LEN  number of 64-bit blocks to move.
- cmd_ready  out  1  high only in IDLE.
- br  out  1  bus request to CPU.
- bg  in  1  bus grant from CPU.
- offset  out  DEVICE_BIT_LEN  block index driven to the device.
- dev_data  in  4*WORD_SIZE  device data for the current offset (combinational in device).
- mem_write  out  1  memory line-write request.
- mem_addr  out  WORD_SIZE  line-write word address.
- mem_wdata  out  4*WORD_SIZE  line-write data.
- mem_ack  in  1  memory accepted the write (sampled on clk).
- busy  out  1  high in every state except IDLE.
- dma_done  out  1  one-cycle completion interrupt.

Behaviour:
- Reset (async, reset_n=0): state IDLE. br=0, offset=all-ones (device drives z), mem_write=0, mem_addr=0, mem_wdata=0, dma_done=0, busy=0. cmd_ready=1 follows from IDLE.
- All outputs are registered except cmd_ready and busy, which decode from the state.
- States: IDLE, REQ, FETCH, WRITE, RELEASE, DONE.
- IDLE: on cmd_valid, latch base=cmd_addr, cnt=min(cmd_blocks, DATA_SIZE), idx=0.
  - cnt==0 -> DONE (no bus request).
  - Otherwise -> REQ.
- REQ: br=1. When bg=1 -> FETCH with offset=idx.
- FETCH: one cycle. offset is held stable; dev_data is captured into mem_wdata at the end of the cycle. mem_addr=base+4*idx, 16-bit modulo (wraps past 0xFFFF). -> WRITE.
- WRITE: mem_write=1 with addr and data held stable until mem_ack=1 is sampled. On ack: mem_write=0, idx++.
  - idx==cnt -> RELEASE.
  - Otherwise -> FETCH with offset=idx.
- Grant loss:
  - bg=0 sampled in FETCH, or in WRITE without mem_ack: mem_write=0 -> REQ, idx unchanged. The same block is re-fetched after regrant.
  - mem_ack and bg=0 in the same cycle: the ack wins and the block counts as written.
- RELEASE: br=0, offset=all-ones. Wait for bg=0 -> DONE. If bg is already 0, the transition happens next cycle.
- DONE: dma_done=1 for exactly one cycle -> IDLE.
- cmd_valid is ignored while busy. A command accepted in IDLE has no effect on a transfer already in flight.
- Latency, full 3-block transfer: bg high and 1-cycle ack. cmd_valid to first mem_write = 2 cycles after grant. Each block takes 2 cycles. dma_done follows RELEASE.
- mem_ack outside WRITE is ignored.
- Reset mid-transfer aborts immediately to the reset values. No partial-completion interrupt is raised.

Decomposition:
- Shared package: WORD_SIZE, DATA_SIZE, DEVICE_BIT_LEN, BLOCK_WORDS=4, OFFSET_IDLE (all-ones), state encoding.
- Single module. The FSM, index counter and address adder are small enough that no sub-module is warranted.

Test Plan:
- Basic transfer: cmd_addr=0x01F4, cmd_blocks=3, bg granted 1 cycle after br, ack 1 cycle after mem_write -> line writes at 0x01F4/0x01F8/0x01FC carrying device blocks 0/1/2 in order. Then br=0, one dma_done pulse, busy=0.
- Zero length: cmd_blocks=0 -> br never asserts; dma_done pulses 2 cycles after cmd_valid.
- Clamp and wrap: cmd_blocks=3 with DATA_SIZE=2, cmd_addr=0xFFFC -> exactly 2 writes, at 0xFFFC and 0x0000.
- Slow memory and grant loss: mem_ack delayed 5 cycles, bg dropped during WRITE of block 1 -> mem_write drops, br stays high. Block 1 is rewritten with identical addr/data after regrant; no block is skipped or duplicated beyond the retry.
- Ack and grant loss together: mem_ack=1 and bg=0 in the same cycle -> the block counts as written; idx advances on regrant.
- Reset mid-WRITE: reset_n pulsed low -> all outputs return to reset values immediately, offset=all-ones, no dma_done. A new command then completes normally.

Source files
------------

// File: rtl/dma_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_controller_pkg
// Brief    : Shared constants, state encoding and helpers for the DMA engine.
// Revision : 1.0
// ============================================================================
package dma_controller_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int DATA_SIZE      = 3;
  localparam int DEVICE_BIT_LEN = 2;
  localparam int BLOCK_WORDS    = 4;

  localparam logic [DEVICE_BIT_LEN-1:0] OFFSET_IDLE = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Requested block count limited to what the device actually holds.
  function automatic int clamp_blocks(input int req, input int lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : dma_controller
// Brief    : Bus-master DMA engine: reads device blocks and writes memory lines.
// Revision : 1.0
// ============================================================================
module dma_controller #(
  parameter int WORD_SIZE      = dma_controller_pkg::WORD_SIZE,
  parameter int DATA_SIZE      = dma_controller_pkg::DATA_SIZE,
  parameter int DEVICE_BIT_LEN = dma_controller_pkg::DEVICE_BIT_LEN
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  input  logic [WORD_SIZE-1:0]      cmd_addr,
  input  logic [DEVICE_BIT_LEN-1:0] cmd_blocks,
  output logic                      cmd_ready,
  output logic                      br,
  input  logic                      bg,
  output logic [DEVICE_BIT_LEN-1:0] offset,
  input  logic [4*WORD_SIZE-1:0]    dev_data,
  output logic                      mem_write,
  output logic [WORD_SIZE-1:0]      mem_addr,
  output logic [4*WORD_SIZE-1:0]    mem_wdata,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic                      dma_done
);
  import dma_controller_pkg::*;

  localparam logic [DEVICE_BIT_LEN-1:0] c_offset_idle = '1;

  state_t                      r_state,     w_state_nxt;
  logic [WORD_SIZE-1:0]        r_base,      w_base_nxt;
  logic [DEVICE_BIT_LEN-1:0]   r_cnt,       w_cnt_nxt;
  logic [DEVICE_BIT_LEN-1:0]   r_idx,       w_idx_nxt;
  logic                        r_br,        w_br_nxt;
  logic [DEVICE_BIT_LEN-1:0]   r_offset,    w_offset_nxt;
  logic                        r_mem_write, w_mem_write_nxt;
  logic [WORD_SIZE-1:0]        r_mem_addr,  w_mem_addr_nxt;
  logic [4*WORD_SIZE-1:0]      r_mem_wdata, w_mem_wdata_nxt;
  logic                        r_dma_done,  w_dma_done_nxt;

  logic [DEVICE_BIT_LEN-1:0]   w_cnt_req;
  logic [DEVICE_BIT_LEN-1:0]   w_idx_inc;
  logic [WORD_SIZE-1:0]        w_line_off;

  assign w_cnt_req  = DEVICE_BIT_LEN'(clamp_blocks(int'(cmd_blocks), DATA_SIZE));
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_line_off = WORD_SIZE'(r_idx) * WORD_SIZE'(BLOCK_WORDS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_br        <= 1'b0;
      r_offset    <= c_offset_idle;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dma_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_br        <= w_br_nxt;
      r_offset    <= w_offset_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_dma_done  <= w_dma_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_br_nxt        = r_br;
    w_offset_nxt    = r_offset;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    // The interrupt is the registered image of the DONE state.
    w_dma_done_nxt  = (r_state == ST_DONE);

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_base_nxt = cmd_addr;
          w_cnt_nxt  = w_cnt_req;
          w_idx_nxt  = '0;
          if (w_cnt_req == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_REQ;
            w_br_nxt    = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (bg) begin
          w_state_nxt  = ST_FETCH;
          w_offset_nxt = r_idx;
        end
      end
      ST_FETCH: begin
        if (!bg) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt     = ST_WRITE;
          w_mem_write_nxt = 1'b1;
          w_mem_addr_nxt  = r_base + w_line_off;
          w_mem_wdata_nxt = dev_data;
        end
      end
      ST_WRITE: begin
        // An ack in the same cycle as a grant drop still retires the block.
        if (mem_ack) begin
          w_mem_write_nxt = 1'b0;
          w_idx_nxt       = w_idx_inc;
          if (w_idx_inc == r_cnt) begin
            w_state_nxt  = ST_RELEASE;
            w_br_nxt     = 1'b0;
            w_offset_nxt = c_offset_idle;
          end else begin
            w_state_nxt  = ST_FETCH;
            w_offset_nxt = w_idx_inc;
          end
        end else if (!bg) begin
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = ST_REQ;
        end
      end
      ST_RELEASE: begin
        if (!bg) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign br        = r_br;
  assign offset    = r_offset;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dma_done  = r_dma_done;

endmodule
`default_nettype wire

// File: tb/tb_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_controller
// Brief    : Directed self-checking bench for dma_controller.
// Revision : 1.0
// ============================================================================
module tb_dma_controller;

  localparam logic [63:0] c_blk0 = 64'hA000_B000_C000_D000;
  localparam logic [63:0] c_blk1 = 64'hA001_B001_C001_D001;
  localparam logic [63:0] c_blk2 = 64'hA002_B002_C002_D002;

  logic        clk;
  logic        reset_n;
  int          n_vec;
  int          n_err;

  logic        cmd_valid, cmd_ready, br, bg, mem_write, mem_ack, busy, dma_done;
  logic [15:0] cmd_addr, mem_addr;
  logic [1:0]  cmd_blocks, offset;
  logic [63:0] dev_data, mem_wdata;

  logic        cmd_valid_b, cmd_ready_b, br_b, bg_b, mem_write_b, mem_ack_b, busy_b, dma_done_b;
  logic [15:0] cmd_addr_b, mem_addr_b;
  logic [1:0]  cmd_blocks_b, offset_b;
  logic [63:0] dev_data_b, mem_wdata_b;

  int          acc_cnt;
  int          acc_base;
  logic [15:0] q_addr_b[$];
  logic [63:0] q_data_b[$];

  function automatic logic [63:0] dev_blk(input logic [1:0] k);
    return 64'hA000_B000_C000_D000 | {4{14'd0, k}};
  endfunction

  assign dev_data   = dev_blk(offset);
  assign dev_data_b = dev_blk(offset_b);
  // Second instance: instant grant and instant ack.
  assign bg_b       = br_b;
  assign mem_ack_b  = mem_write_b;

  dma_controller u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_blocks(cmd_blocks), .cmd_ready(cmd_ready), .br(br), .bg(bg),
    .offset(offset), .dev_data(dev_data), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .dma_done(dma_done)
  );

  dma_controller #(.DATA_SIZE(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_addr(cmd_addr_b),
    .cmd_blocks(cmd_blocks_b), .cmd_ready(cmd_ready_b), .br(br_b), .bg(bg_b),
    .offset(offset_b), .dev_data(dev_data_b), .mem_write(mem_write_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ack(mem_ack_b),
    .busy(busy_b), .dma_done(dma_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial acc_cnt = 0;
  always @(negedge clk) begin
    if (mem_write && mem_ack) acc_cnt = acc_cnt + 1;
    if (mem_write_b && mem_ack_b) begin
      q_addr_b.push_back(mem_addr_b);
      q_data_b.push_back(mem_wdata_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; bg = 1'b0; mem_ack = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_blocks = '0;
    cmd_valid_b = 1'b0; cmd_addr_b = '0; cmd_blocks_b = '0;
    repeat (2) tick();

    chk("rst br", br, 0);
    chk("rst offset", offset, 2'b11);
    chk("rst mem_write", mem_write, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst dma_done", dma_done, 0);
    chk("rst busy", busy, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    reset_n = 1'b1;
    tick();

    // Basic three-block transfer, with an ignored command mid-flight
    acc_base = acc_cnt;
    cmd_valid = 1'b1; cmd_addr = 16'h01F4; cmd_blocks = 2'd3;
    tick();
    cmd_valid = 1'b0;
    chk("basic br", br, 1);
    chk("basic busy", busy, 1);
    chk("basic cmd_ready", cmd_ready, 0);
    bg = 1'b1;
    tick();
    chk("basic offset0", offset, 0);
    chk("basic no write yet", mem_write, 0);
    tick();
    chk("basic wr0", mem_write, 1);
    chk("basic addr0", mem_addr, 16'h01F4);
    chk("basic data0", mem_wdata, c_blk0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("basic wr drop", mem_write, 0);
    chk("basic offset1", offset, 1);
    cmd_valid = 1'b1; cmd_addr = 16'h1234; cmd_blocks = 2'd1;
    tick();
    cmd_valid = 1'b0;
    chk("basic wr1", mem_write, 1);
    chk("basic addr1", mem_addr, 16'h01F8);
    chk("basic data1", mem_wdata, c_blk1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("basic offset2", offset, 2);
    tick();
    chk("basic addr2", mem_addr, 16'h01FC);
    chk("basic data2", mem_wdata, c_blk2);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("basic release br", br, 0);
    chk("basic release offset", offset, 2'b11);
    chk("basic release busy", busy, 1);
    bg = 1'b0;
    tick();
    chk("basic done early", dma_done, 0);
    tick();
    chk("basic done pulse", dma_done, 1);
    chk("basic idle busy", busy, 0);
    tick();
    chk("basic done one cycle", dma_done, 0);
    chk("basic write count", 64'(acc_cnt - acc_base), 3);

    // Zero-length command
    cmd_valid = 1'b1; cmd_addr = 16'h0040; cmd_blocks = 2'd0;
    tick();
    cmd_valid = 1'b0;
    chk("zero br", br, 0);
    chk("zero busy", busy, 1);
    chk("zero done early", dma_done, 0);
    tick();
    chk("zero done", dma_done, 1);
    chk("zero br after", br, 0);
    tick();

    // Slow memory with grant loss during block 1
    acc_base = acc_cnt;
    cmd_valid = 1'b1; cmd_addr = 16'h0100; cmd_blocks = 2'd2;
    tick();
    cmd_valid = 1'b0; bg = 1'b1;
    tick();
    tick();
    chk("slow addr0", mem_addr, 16'h0100);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("slow addr1", mem_addr, 16'h0104);
    tick();
    tick();
    chk("slow wr held", mem_write, 1);
    bg = 1'b0;
    tick();
    chk("slow loss wr", mem_write, 0);
    chk("slow loss br", br, 1);
    tick();
    chk("slow wait br", br, 1);
    chk("slow wait wr", mem_write, 0);
    bg = 1'b1;
    tick();
    chk("slow refetch offset", offset, 1);
    tick();
    chk("slow retry wr", mem_write, 1);
    chk("slow retry addr", mem_addr, 16'h0104);
    chk("slow retry data", mem_wdata, c_blk1);
    repeat (4) tick();
    chk("slow retry held", mem_write, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("slow release br", br, 0);
    chk("slow release wr", mem_write, 0);
    bg = 1'b0;
    tick();
    tick();
    chk("slow done", dma_done, 1);
    chk("slow write count", 64'(acc_cnt - acc_base), 2);

    // Ack and grant loss in the same cycle
    acc_base = acc_cnt;
    cmd_valid = 1'b1; cmd_addr = 16'h0200; cmd_blocks = 2'd2;
    tick();
    cmd_valid = 1'b0; bg = 1'b1;
    tick();
    tick();
    chk("both addr0", mem_addr, 16'h0200);
    mem_ack = 1'b1; bg = 1'b0;
    tick();
    mem_ack = 1'b0;
    chk("both wr drop", mem_write, 0);
    chk("both offset advanced", offset, 1);
    chk("both br held", br, 1);
    tick();
    chk("both req br", br, 1);
    bg = 1'b1;
    tick();
    tick();
    chk("both addr1", mem_addr, 16'h0204);
    chk("both data1", mem_wdata, c_blk1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("both release br", br, 0);
    bg = 1'b0;
    tick();
    tick();
    chk("both done", dma_done, 1);
    chk("both write count", 64'(acc_cnt - acc_base), 2);

    // Reset during WRITE, then a fresh command
    bg = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 16'h0300; cmd_blocks = 2'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rstmid wr", mem_write, 1);
    chk("rstmid addr", mem_addr, 16'h0300);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid br", br, 0);
    chk("rstmid offset", offset, 2'b11);
    chk("rstmid mem_write", mem_write, 0);
    chk("rstmid mem_addr", mem_addr, 0);
    chk("rstmid mem_wdata", mem_wdata, 0);
    chk("rstmid busy", busy, 0);
    bg = 1'b0;
    tick();
    tick();
    chk("rstmid no done", dma_done, 0);
    reset_n = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_addr = 16'h0010; cmd_blocks = 2'd1;
    tick();
    cmd_valid = 1'b0; bg = 1'b1;
    tick();
    tick();
    chk("post addr", mem_addr, 16'h0010);
    chk("post data", mem_wdata, c_blk0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("post release br", br, 0);
    bg = 1'b0;
    tick();
    tick();
    chk("post done", dma_done, 1);

    // Clamp to DATA_SIZE=2 and 16-bit address wrap
    cmd_valid_b = 1'b1; cmd_addr_b = 16'hFFFC; cmd_blocks_b = 2'd3;
    tick();
    cmd_valid_b = 1'b0;
    for (int n = 0; n < 20 && !dma_done_b; n++) tick();
    chk("clamp done", dma_done_b, 1);
    chk("clamp count", 64'(q_addr_b.size()), 2);
    if (q_addr_b.size() >= 2) begin
      chk("clamp addr0", q_addr_b[0], 16'hFFFC);
      chk("clamp addr1", q_addr_b[1], 16'h0000);
      chk("clamp data0", q_data_b[0], c_blk0);
      chk("clamp data1", q_data_b[1], c_blk1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
